sc1602_ctrl: RTL and testbench
==============================

SC1602_CTRL -- requirements
Module: sc1602_ctrl

Interface
REQ-001 Parameter T_PWR, default 360000: power-up wait in clk cycles (40 ms at 9 MHz).
REQ-002 Parameter T_INIT, default 37000: wait after first init nibble (4.1 ms).
REQ-003 Parameter T_SHORT, default 1000: wait after second init nibble (100 us).
REQ-004 Parameter T_EXEC, default 400: execution wait after normal byte (40 us + margin).
REQ-005 Parameter T_CLR, default 15000: execution wait after clear or home command (1.64 ms).
REQ-006 Parameter T_E, default 5: E-high cycles, also E-low hold cycles per nibble.
REQ-007 clk  in  1  system clock, the rPLL clkout (9 MHz); all logic on the rising edge.
REQ-008 rst_n  in  1  asynchronous active-low reset.
REQ-009 pll_lock  in  1  rPLL lock; low holds the block in power-up state.
REQ-010 wr_valid  in  1  write request.
REQ-011 wr_rs  in  1  0 = command, 1 = character data.
REQ-012 wr_data  in  8  byte to write.
REQ-013 wr_ready  out  1  block accepts a byte this cycle.
REQ-014 init_done  out  1  HD44780 init sequence complete.
REQ-015 lcd_rs, lcd_rw, lcd_e  out  1 each  LCD control pins; lcd_rw is constant 0.
REQ-016 lcd_db  out  4  LCD DB[7:4], 4-bit mode.

Function
REQ-017 pll_lock SHALL pass through a 2-flop synchronizer; sync low forces state PWR, init_done=0, wr_ready=0, lcd_e=0 on the next edge.
REQ-018 States SHALL be PWR, INIT, IDLE, SETUP, EHI, ELO, WAIT.
REQ-019 PWR: counter runs only while synced lock is high; after T_PWR cycles go to INIT.
REQ-020 Nibble timing SHALL be: 1 SETUP cycle (RS/DB valid, E=0), then T_E EHI cycles (E=1), then T_E ELO cycles (E=0, RS/DB held): 1+2*T_E cycles.
REQ-021 A byte SHALL be sent as high nibble then low nibble, back to back, then WAIT.
REQ-022 WAIT length SHALL be T_CLR when rs=0 and data is 0x01 or 0x02, else T_EXEC.
REQ-023 Init sequence, all rs=0, SHALL be:
  - nibble 0x3, wait T_INIT; nibble 0x3, wait T_SHORT
  - nibble 0x3, wait T_EXEC; nibble 0x2, wait T_EXEC
  - bytes 0x28, 0x0C, 0x01 (T_CLR), 0x06
  - then init_done=1 and enter IDLE.
REQ-024 wr_ready SHALL be 1 only in IDLE with init_done=1; transfer occurs on an edge with wr_valid=1 and wr_ready=1.
REQ-025 wr_rs and wr_data SHALL be latched at transfer; later input changes are ignored until the next transfer.
REQ-026 After a transfer at edge k, wr_ready SHALL be 0 until edge k+2*(1+2*T_E)+T_WAIT, where it returns to 1.
REQ-027 wr_valid while wr_ready=0 SHALL be ignored and never queued.
REQ-028 All wait counters SHALL be wide enough for the largest parameter and SHALL NOT wrap.
REQ-029 lcd_db and lcd_rs SHALL change only in SETUP cycles or on entering PWR.

Reset
REQ-030 On rst_n low, outputs SHALL immediately be: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_db=0, wr_ready=0, init_done=0; state PWR; counters 0.
REQ-031 After rst_n rises, the full power-up and init sequence SHALL rerun.
REQ-032 Reset or lock loss during a transfer SHALL abort it with no further E pulse.

Verification (T_PWR=20, T_INIT=10, T_SHORT=6, T_EXEC=4, T_CLR=8, T_E=2)
REQ-033 Lock high from reset: lcd_e pulses carry 0x3,0x3,0x3,0x2,2,8,0,C,0,1,0,6 (rs=0), each pulse 2 cycles high; then init_done=1, wr_ready=1.
REQ-034 Transfer rs=1 data 0x41: DB=4 then 1, lcd_rs=1; wr_ready back high exactly 14 cycles after the accept edge.
REQ-035 Transfer rs=0 data 0x01: wait uses T_CLR; wr_ready returns after 18 cycles.
REQ-036 wr_valid held high with changing data during busy: only the byte present at each accept edge appears on lcd_db.
REQ-037 Drop pll_lock mid-EHI: lcd_e=0 within 3 edges, init_done=0; after relock, the full init sequence repeats.
REQ-038 Assert rst_n low during WAIT: all outputs at reset values asynchronously; after release, PWR lasts 20 cycles.

Source files
------------

// File: rtl/sc1602_ctrl.sv
// SC1602 (HD44780) character LCD controller, 4-bit bus, write-only.
// Runs the power-up wait and init sequence after PLL lock, then accepts
// command/data bytes over a valid/ready handshake and sends them as two
// E-strobed nibbles followed by the controller execution wait.
module sc1602_ctrl #(
  parameter int unsigned T_PWR   = 360000,
  parameter int unsigned T_INIT  = 37000,
  parameter int unsigned T_SHORT = 1000,
  parameter int unsigned T_EXEC  = 400,
  parameter int unsigned T_CLR   = 15000,
  parameter int unsigned T_E     = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  input  logic       wr_valid,
  input  logic       wr_rs,
  input  logic [7:0] wr_data,
  output logic       wr_ready,
  output logic       init_done,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_e,
  output logic [3:0] lcd_db
);

  localparam int unsigned MAX_A      = (T_PWR > T_INIT) ? T_PWR : T_INIT;
  localparam int unsigned MAX_B      = (T_SHORT > T_EXEC) ? T_SHORT : T_EXEC;
  localparam int unsigned MAX_C      = (T_CLR > T_E) ? T_CLR : T_E;
  localparam int unsigned MAX_AB     = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_T      = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int unsigned CNT_W      = (MAX_T < 2) ? 1 : $clog2(MAX_T + 1);
  localparam int unsigned STEP_W     = 4;
  localparam int unsigned INIT_STEPS = 8;
  localparam int unsigned NIB_STEPS  = 4;

  typedef enum logic [2:0] {
    ST_PWR   = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_SETUP = 3'd3,
    ST_EHI   = 3'd4,
    ST_ELO   = 3'd5,
    ST_WAIT  = 3'd6
  } state_t;

  // Init step table: steps 0-3 are single high nibbles, 4-7 full bytes.
  function automatic logic [7:0] init_byte(input logic [STEP_W-1:0] s);
    case (s)
      4'd0, 4'd1, 4'd2: init_byte = 8'h30;
      4'd3:             init_byte = 8'h20;
      4'd4:             init_byte = 8'h28;
      4'd5:             init_byte = 8'h0C;
      4'd6:             init_byte = 8'h01;
      4'd7:             init_byte = 8'h06;
      default:          init_byte = 8'h00;
    endcase
  endfunction

  // Execution wait that follows each init step.
  function automatic logic [CNT_W-1:0] init_wait(input logic [STEP_W-1:0] s);
    case (s)
      4'd0:    init_wait = CNT_W'(T_INIT);
      4'd1:    init_wait = CNT_W'(T_SHORT);
      4'd6:    init_wait = CNT_W'(T_CLR);
      default: init_wait = CNT_W'(T_EXEC);
    endcase
  endfunction

  state_t            state_q,     state_d;
  logic [CNT_W-1:0]  cnt_q,       cnt_d;
  logic [CNT_W-1:0]  wait_q,      wait_d;
  logic [STEP_W-1:0] step_q,      step_d;
  logic [3:0]        lo_nib_q,    lo_nib_d;
  logic              low_q,       low_d;
  logic              single_q,    single_d;
  logic              init_done_q, init_done_d;
  logic              wr_ready_q,  wr_ready_d;
  logic              lcd_e_q,     lcd_e_d;
  logic              lcd_rs_q,    lcd_rs_d;
  logic [3:0]        lcd_db_q,    lcd_db_d;
  logic              lock_meta_q, lock_meta_d;
  logic              lock_sync_q, lock_sync_d;

  logic [7:0]        init_item;
  logic              user_clr;

  assign init_item = init_byte(step_q);
  assign user_clr  = !wr_rs && ((wr_data == 8'h01) || (wr_data == 8'h02));

  // Next-state and registered-output logic; lock loss overrides everything.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    wait_d      = wait_q;
    step_d      = step_q;
    lo_nib_d    = lo_nib_q;
    low_d       = low_q;
    single_d    = single_q;
    init_done_d = init_done_q;
    wr_ready_d  = wr_ready_q;
    lcd_e_d     = lcd_e_q;
    lcd_rs_d    = lcd_rs_q;
    lcd_db_d    = lcd_db_q;
    lock_meta_d = pll_lock;
    lock_sync_d = lock_meta_q;

    if (!lock_sync_q) begin
      state_d     = ST_PWR;
      cnt_d       = '0;
      step_d      = '0;
      low_d       = 1'b0;
      single_d    = 1'b0;
      init_done_d = 1'b0;
      wr_ready_d  = 1'b0;
      lcd_e_d     = 1'b0;
      lcd_rs_d    = 1'b0;
      lcd_db_d    = 4'h0;
    end else begin
      case (state_q)
        ST_PWR: begin
          if (cnt_q == CNT_W'(T_PWR - 1)) begin
            cnt_d   = '0;
            state_d = ST_INIT;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_INIT: begin
          if (step_q == STEP_W'(INIT_STEPS)) begin
            init_done_d = 1'b1;
            wr_ready_d  = 1'b1;
            state_d     = ST_IDLE;
          end else begin
            lcd_rs_d = 1'b0;
            lcd_db_d = init_item[7:4];
            lo_nib_d = init_item[3:0];
            single_d = (step_q < STEP_W'(NIB_STEPS));
            low_d    = 1'b0;
            wait_d   = init_wait(step_q);
            step_d   = step_q + STEP_W'(1);
            state_d  = ST_SETUP;
          end
        end

        ST_IDLE: begin
          if (wr_valid && wr_ready_q) begin
            lcd_rs_d   = wr_rs;
            lcd_db_d   = wr_data[7:4];
            lo_nib_d   = wr_data[3:0];
            single_d   = 1'b0;
            low_d      = 1'b0;
            wait_d     = user_clr ? CNT_W'(T_CLR) : CNT_W'(T_EXEC);
            wr_ready_d = 1'b0;
            state_d    = ST_SETUP;
          end
        end

        ST_SETUP: begin
          cnt_d   = '0;
          lcd_e_d = 1'b1;
          state_d = ST_EHI;
        end

        ST_EHI: begin
          if (cnt_q == CNT_W'(T_E - 1)) begin
            cnt_d   = '0;
            lcd_e_d = 1'b0;
            state_d = ST_ELO;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_ELO: begin
          if (cnt_q == CNT_W'(T_E - 1)) begin
            cnt_d = '0;
            if (!single_q && !low_q) begin
              low_d    = 1'b1;
              lcd_db_d = lo_nib_q;
              state_d  = ST_SETUP;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        ST_WAIT: begin
          if (cnt_q == wait_q - CNT_W'(1)) begin
            cnt_d = '0;
            if (init_done_q) begin
              wr_ready_d = 1'b1;
              state_d    = ST_IDLE;
            end else begin
              state_d = ST_INIT;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end

        default: begin
          cnt_d   = '0;
          state_d = ST_PWR;
        end
      endcase
    end
  end

  // State, counters, lock synchronizer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_PWR;
      cnt_q       <= '0;
      wait_q      <= '0;
      step_q      <= '0;
      lo_nib_q    <= 4'h0;
      low_q       <= 1'b0;
      single_q    <= 1'b0;
      init_done_q <= 1'b0;
      wr_ready_q  <= 1'b0;
      lcd_e_q     <= 1'b0;
      lcd_rs_q    <= 1'b0;
      lcd_db_q    <= 4'h0;
      lock_meta_q <= 1'b0;
      lock_sync_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wait_q      <= wait_d;
      step_q      <= step_d;
      lo_nib_q    <= lo_nib_d;
      low_q       <= low_d;
      single_q    <= single_d;
      init_done_q <= init_done_d;
      wr_ready_q  <= wr_ready_d;
      lcd_e_q     <= lcd_e_d;
      lcd_rs_q    <= lcd_rs_d;
      lcd_db_q    <= lcd_db_d;
      lock_meta_q <= lock_meta_d;
      lock_sync_q <= lock_sync_d;
    end
  end

  assign wr_ready  = wr_ready_q;
  assign init_done = init_done_q;
  assign lcd_rs    = lcd_rs_q;
  assign lcd_rw    = 1'b0;
  assign lcd_e     = lcd_e_q;
  assign lcd_db    = lcd_db_q;

endmodule

// File: tb/tb_sc1602_ctrl.sv
// Self-checking bench for sc1602_ctrl: observes E strobes as a nibble stream
// and compares against the expected init sequence and accepted bytes.
module tb_sc1602_ctrl;

  localparam int T_PWR   = 20;
  localparam int T_INIT  = 10;
  localparam int T_SHORT = 6;
  localparam int T_EXEC  = 4;
  localparam int T_CLR   = 8;
  localparam int T_E     = 2;
  localparam int NIB_CYC = 1 + 2 * T_E;

  logic       clk      = 1'b0;
  logic       rst_n    = 1'b1;
  logic       pll_lock = 1'b1;
  logic       wr_valid = 1'b0;
  logic       wr_rs    = 1'b0;
  logic [7:0] wr_data  = 8'h00;
  logic       wr_ready, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [3:0] lcd_db;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int n_rise = 0;
  int first_rise = -1;
  int rel_cyc    = 0;
  int e_len      = 0;
  logic       e_prev   = 1'b0;
  logic [4:0] rise_val = 5'h00;
  logic [4:0] obs_q[$];
  logic [4:0] init_exp[$];
  logic [8:0] acc_q[$];

  sc1602_ctrl #(
    .T_PWR(T_PWR), .T_INIT(T_INIT), .T_SHORT(T_SHORT),
    .T_EXEC(T_EXEC), .T_CLR(T_CLR), .T_E(T_E)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock),
    .wr_valid(wr_valid), .wr_rs(wr_rs), .wr_data(wr_data),
    .wr_ready(wr_ready), .init_done(init_done),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // E strobe monitor: records {rs,db} at each rising E, checks width and hold.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (lcd_e && !e_prev) begin
        rise_val = {lcd_rs, lcd_db};
        obs_q.push_back(rise_val);
        n_rise++;
        e_len = 1;
        if (first_rise < 0) first_rise = cyc;
      end else if (lcd_e) begin
        e_len++;
        chk("db_hold_e_high", {27'd0, lcd_rs, lcd_db}, {27'd0, rise_val});
      end else if (e_prev && rst_n && pll_lock) begin
        chk("e_width", e_len, T_E);
      end
      e_prev = lcd_e;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!wr_ready && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk(tag, wr_ready, 1);
  endtask

  task automatic wait_init(input string tag);
    int n;
    n = 0;
    while (!init_done && n < 1500) begin
      @(negedge clk);
      n++;
    end
    chk(tag, init_done, 1);
    chk({tag, "_ready"}, wr_ready, 1);
  endtask

  task automatic check_pwr_window(input string tag);
    int d;
    d = first_rise - rel_cyc;
    chk(tag, (first_rise >= 0 && d >= T_PWR + 2 && d <= T_PWR + 5) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic check_init_seq(input string tag);
    chk({tag, "_count"}, obs_q.size(), init_exp.size());
    for (int i = 0; i < init_exp.size(); i++) begin
      if (i < obs_q.size())
        chk($sformatf("%s_nib%0d", tag, i), {27'd0, obs_q[i]}, {27'd0, init_exp[i]});
    end
    obs_q.delete();
  endtask

  task automatic release_and_capture(input bit use_reset);
    @(negedge clk);
    #1;
    obs_q.delete();
    rel_cyc    = cyc;
    first_rise = -1;
    if (use_reset) rst_n = 1'b1;
    else           pll_lock = 1'b1;
  endtask

  task automatic send(input logic rs, input logic [7:0] d);
    int n;
    int exp_gap;
    wait_ready("ready_before_send");
    obs_q.delete();
    wr_valid = 1'b1;
    wr_rs    = rs;
    wr_data  = d;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    wr_rs    = ~rs;
    wr_data  = ~d;
    @(negedge clk);
    chk("busy_after_accept", wr_ready, 0);
    n = 0;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    exp_gap = 2 * NIB_CYC + ((!rs && (d == 8'h01 || d == 8'h02)) ? T_CLR : T_EXEC);
    chk($sformatf("ready_gap_rs%0d_%02h", rs, d), n, exp_gap);
    chk("nib_count", obs_q.size(), 2);
    if (obs_q.size() >= 2) begin
      chk("nib_hi", {27'd0, obs_q[0]}, {27'd0, rs, d[7:4]});
      chk("nib_lo", {27'd0, obs_q[1]}, {27'd0, rs, d[3:0]});
    end
    chk("rw_low", lcd_rw, 0);
  endtask

  initial begin
    int n;
    int rises;
    logic acc;
    logic [7:0] b;
    logic [7:0] init_bytes[4];

    init_bytes = '{8'h28, 8'h0C, 8'h01, 8'h06};
    init_exp.push_back(5'h03);
    init_exp.push_back(5'h03);
    init_exp.push_back(5'h03);
    init_exp.push_back(5'h02);
    for (int i = 0; i < 4; i++) begin
      b = init_bytes[i];
      init_exp.push_back({1'b0, b[7:4]});
      init_exp.push_back({1'b0, b[3:0]});
    end

    // Asynchronous reset between clock edges.
    #1 rst_n = 1'b0;
    #2;
    chk("rst_lcd_e", lcd_e, 0);
    chk("rst_lcd_rs", lcd_rs, 0);
    chk("rst_lcd_rw", lcd_rw, 0);
    chk("rst_lcd_db", lcd_db, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_init_done", init_done, 0);
    repeat (3) @(negedge clk);

    // Power-up and init with lock already high.
    release_and_capture(1'b1);
    wait_init("init1");
    check_pwr_window("pwr_len1");
    check_init_seq("init1");

    // Directed bytes, including the clear/home long waits.
    send(1'b1, 8'h41);
    send(1'b0, 8'h01);
    send(1'b0, 8'h02);
    send(1'b0, 8'h03);
    send(1'b1, 8'h01);

    // Random bytes, biased towards the clear/home commands.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 3) == 0) send(1'b0, 8'($urandom_range(1, 2)));
      else                           send(1'($urandom_range(0, 1)), 8'($urandom));
    end

    // wr_valid held high with data changing every cycle.
    wait_ready("ready_before_stream");
    obs_q.delete();
    acc_q.delete();
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      wr_valid = 1'b1;
      wr_rs    = 1'($urandom_range(0, 1));
      wr_data  = 8'($urandom);
      acc      = wr_ready;
      @(posedge clk);
      if (acc) acc_q.push_back({wr_rs, wr_data});
    end
    @(negedge clk);
    wr_valid = 1'b0;
    n = 0;
    while (!wr_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("stream_drain", wr_ready, 1);
    chk("stream_accepts_ge3", (acc_q.size() >= 3) ? 32'd1 : 32'd0, 32'd1);
    chk("stream_nib_count", obs_q.size(), 2 * acc_q.size());
    for (int i = 0; i < acc_q.size(); i++) begin
      if (2 * i + 1 < obs_q.size()) begin
        chk($sformatf("stream_hi%0d", i), {27'd0, obs_q[2*i]},   {27'd0, acc_q[i][8], acc_q[i][7:4]});
        chk($sformatf("stream_lo%0d", i), {27'd0, obs_q[2*i+1]}, {27'd0, acc_q[i][8], acc_q[i][3:0]});
      end
    end

    // Lock loss during an E-high phase.
    wait_ready("ready_before_lockdrop");
    wr_valid = 1'b1;
    wr_rs    = 1'b1;
    wr_data  = 8'h5A;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!lcd_e && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("e_high_before_drop", lcd_e, 1);
    pll_lock = 1'b0;
    repeat (3) @(negedge clk);
    chk("unlock_lcd_e", lcd_e, 0);
    chk("unlock_init_done", init_done, 0);
    chk("unlock_wr_ready", wr_ready, 0);
    chk("unlock_lcd_db", lcd_db, 0);
    chk("unlock_lcd_rs", lcd_rs, 0);
    rises = n_rise;
    repeat (2 * T_PWR + 10) @(negedge clk);
    chk("no_pulse_unlocked", n_rise - rises, 0);
    chk("ready_low_unlocked", wr_ready, 0);
    release_and_capture(1'b0);
    wait_init("relock");
    check_pwr_window("pwr_len_relock");
    check_init_seq("relock");
    send(1'b1, 8'h33);

    // Reset asserted mid-WAIT.
    wait_ready("ready_before_reset");
    wr_valid = 1'b1;
    wr_rs    = 1'b0;
    wr_data  = 8'h0C;
    @(posedge clk);
    #1;
    wr_valid = 1'b0;
    repeat (2 * NIB_CYC) @(posedge clk);
    #2;
    chk("busy_in_wait", wr_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("rst2_lcd_e", lcd_e, 0);
    chk("rst2_lcd_rs", lcd_rs, 0);
    chk("rst2_lcd_db", lcd_db, 0);
    chk("rst2_lcd_rw", lcd_rw, 0);
    chk("rst2_wr_ready", wr_ready, 0);
    chk("rst2_init_done", init_done, 0);
    rises = n_rise;
    repeat (10) @(negedge clk);
    chk("no_pulse_in_reset", n_rise - rises, 0);
    release_and_capture(1'b1);
    wait_init("init3");
    check_pwr_window("pwr_len3");
    check_init_seq("init3");
    send(1'b1, 8'h7E);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
